// File: rtl/mont_exp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer: default sizes,
// FSM state encoding and the Montgomery "one" operand.
package mont_exp_ctrl_pkg;

    localparam int DEF_WIDTH  = 512;
    localparam int DEF_ELEN_W = 10;

    localparam logic [DEF_WIDTH-1:0] ONE = {{(DEF_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ISS_TOM  = 4'd1,
        S_W_TOM    = 4'd2,
        S_ISS_SQ   = 4'd3,
        S_W_SQ     = 4'd4,
        S_ISS_MUL  = 4'd5,
        S_W_MUL    = 4'd6,
        S_NEXT     = 4'd7,
        S_ISS_FROM = 4'd8,
        S_W_FROM   = 4'd9,
        S_DONE     = 4'd10
    } state_e;

    // Issue states are the only ones that pulse the multiplier start.
    function automatic logic is_iss(input state_e s);
        return (s == S_ISS_TOM) || (s == S_ISS_SQ) ||
               (s == S_ISS_MUL) || (s == S_ISS_FROM);
    endfunction

endpackage

// File: rtl/mont_exp_ctrl_exp_bit_ctr.sv
// Holds the latched exponent and the bit index walked from e_len-1 down to 0;
// presents the current exponent bit and whether it is the last one.
module mont_exp_ctrl_exp_bit_ctr #(
    parameter int WIDTH  = 512,
    parameter int ELEN_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  e_i,
    input  logic [ELEN_W-1:0] e_len_i,
    input  logic              dec_i,
    output logic              bit_o,
    output logic              last_o
);

    logic [WIDTH-1:0]  e_q;
    logic [ELEN_W-1:0] i_q;
    logic [ELEN_W-1:0] i_d;

    always_comb begin
        i_d = i_q;
        if (load_i) begin
            i_d = e_len_i - ELEN_W'(1);
        end else if (dec_i) begin
            i_d = i_q - ELEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            i_q <= '0;
        end else begin
            i_q <= i_d;
        end
    end

    // Exponent is pure data and needs no reset; it is only read after a load.
    always_ff @(posedge clk) begin
        if (load_i) begin
            e_q <= e_i;
        end
    end

    assign bit_o  = |(e_q & (WIDTH'(1) << i_q));
    assign last_o = (i_q == '0);

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery
// multiplier through a start/done handshake; computes x^e mod M.
module mont_exp_ctrl
    import mont_exp_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ELEN_W = DEF_ELEN_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_e,
    input  logic [ELEN_W-1:0] in_e_len,
    input  logic [WIDTH-1:0]  in_m,
    input  logic [WIDTH-1:0]  in_r,
    input  logic [WIDTH-1:0]  in_r2,
    output logic [WIDTH-1:0]  result,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic              mm_start,
    output logic [WIDTH-1:0]  mm_a,
    output logic [WIDTH-1:0]  mm_b,
    output logic [WIDTH-1:0]  mm_m,
    input  logic [WIDTH+1:0]  mm_result,
    input  logic              mm_done
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] xt_q, xt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] mm_a_q, mm_a_d;
    logic [WIDTH-1:0] mm_b_q, mm_b_d;
    logic [WIDTH-1:0] mm_m_q, mm_m_d;
    logic             err_q, err_d;
    logic             elen_nz_q, elen_nz_d;

    logic             load_ctr;
    logic             dec_ctr;
    logic             cap;
    logic             e_bit;
    logic             e_last;
    logic [WIDTH-1:0] prod;
    logic             ovf;

    assign prod = mm_result[WIDTH-1:0];
    assign ovf  = |mm_result[WIDTH+1:WIDTH];

    mont_exp_ctrl_exp_bit_ctr #(
        .WIDTH  (WIDTH),
        .ELEN_W (ELEN_W)
    ) u_exp_bit_ctr (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (load_ctr),
        .e_i     (in_e),
        .e_len_i (in_e_len),
        .dec_i   (dec_ctr),
        .bit_o   (e_bit),
        .last_o  (e_last)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        xt_d      = xt_q;
        result_d  = result_q;
        err_d     = err_q;
        elen_nz_d = elen_nz_q;
        mm_a_d    = mm_a_q;
        mm_b_d    = mm_b_q;
        mm_m_d    = mm_m_q;
        load_ctr  = 1'b0;
        dec_ctr   = 1'b0;
        cap       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_ISS_TOM;
                    a_d       = in_r;
                    err_d     = 1'b0;
                    elen_nz_d = |in_e_len;
                    load_ctr  = 1'b1;
                    // x, r2 and M live in the operand registers from here on.
                    mm_a_d    = in_x;
                    mm_b_d    = in_r2;
                    mm_m_d    = in_m;
                end
            end
            S_ISS_TOM:  state_d = S_W_TOM;
            S_ISS_SQ:   state_d = S_W_SQ;
            S_ISS_MUL:  state_d = S_W_MUL;
            S_ISS_FROM: state_d = S_W_FROM;
            S_W_TOM: begin
                if (mm_done) begin
                    cap     = 1'b1;
                    xt_d    = prod;
                    state_d = elen_nz_q ? S_ISS_SQ : S_ISS_FROM;
                end
            end
            S_W_SQ: begin
                if (mm_done) begin
                    cap     = 1'b1;
                    a_d     = prod;
                    state_d = e_bit ? S_ISS_MUL : S_NEXT;
                end
            end
            S_W_MUL: begin
                if (mm_done) begin
                    cap     = 1'b1;
                    a_d     = prod;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (e_last) begin
                    state_d = S_ISS_FROM;
                end else begin
                    dec_ctr = 1'b1;
                    state_d = S_ISS_SQ;
                end
            end
            S_W_FROM: begin
                if (mm_done) begin
                    cap      = 1'b1;
                    result_d = prod;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cap && ovf) begin
            err_d = 1'b1;
        end

        // Operands change only on the edge into an issue state and then stay
        // put for the whole bit-serial multiply.
        case (state_d)
            S_ISS_SQ: begin
                mm_a_d = a_d;
                mm_b_d = a_d;
            end
            S_ISS_MUL: begin
                mm_a_d = a_d;
                mm_b_d = xt_q;
            end
            S_ISS_FROM: begin
                mm_a_d = a_d;
                mm_b_d = WIDTH'(ONE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            err_q    <= 1'b0;
            result_q <= '0;
            mm_a_q   <= '0;
            mm_b_q   <= '0;
            mm_m_q   <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            result_q <= result_d;
            mm_a_q   <= mm_a_d;
            mm_b_q   <= mm_b_d;
            mm_m_q   <= mm_m_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q       <= a_d;
        xt_q      <= xt_d;
        elen_nz_q <= elen_nz_d;
    end

    assign result   = result_q;
    assign err      = err_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_m     = mm_m_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign mm_start = is_iss(state_q);

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench for mont_exp_ctrl with a fixed-latency Montgomery multiplier mock.
module tb_mont_exp_ctrl;

    localparam int W  = 512;
    localparam int EW = 10;
    localparam int L  = 3;
    localparam int M  = 497;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [W-1:0]  in_x, in_e, in_m, in_r, in_r2;
    logic [EW-1:0] in_e_len;
    logic [W-1:0]  result;
    logic          done, busy, err, mm_start;
    logic [W-1:0]  mm_a, mm_b, mm_m;
    logic [W+1:0]  mm_result;
    logic          mm_done;

    always #5 clk = ~clk;

    mont_exp_ctrl #(.WIDTH(W), .ELEN_W(EW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .in_x      (in_x),
        .in_e      (in_e),
        .in_e_len  (in_e_len),
        .in_m      (in_m),
        .in_r      (in_r),
        .in_r2     (in_r2),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_m      (mm_m),
        .mm_result (mm_result),
        .mm_done   (mm_done)
    );

    // a*b*2^-W mod m, bit-serial Montgomery with final reduction
    function automatic longint mont(input longint a, input longint b, input longint m);
        longint t = 0;
        for (int i = 0; i < W; i++) begin
            if (i < 62 && ((a >> i) & 64'd1) == 64'd1) t = t + b;
            if ((t & 64'd1) == 64'd1) t = t + m;
            t = t >> 1;
        end
        if (t >= m) t = t - m;
        return t;
    endfunction

    function automatic longint r_mod(input longint m);
        longint r = 1;
        for (int i = 0; i < W; i++) r = (r * 2) % m;
        return r;
    endfunction

    // Mock multiplier: done rises in the L-th cycle after the start pulse.
    int mk_cnt = 0;
    int mk_ops = 0;
    int inj_at = -1;
    always @(posedge clk) begin
        if (!resetn) begin
            mm_done   <= 1'b0;
            mk_cnt    <= 0;
            mm_result <= '0;
        end else if (mm_start) begin
            mm_done   <= 1'b0;
            mk_cnt    <= L - 1;
            mk_ops    <= mk_ops + 1;
            mm_result <= {(mk_ops == inj_at) ? 2'b01 : 2'b00,
                          W'(mont(longint'(mm_a[31:0]), longint'(mm_b[31:0]), longint'(mm_m[31:0])))};
        end else if (mk_cnt != 0) begin
            mk_cnt <= mk_cnt - 1;
            if (mk_cnt == 1) mm_done <= 1'b1;
        end
    end

    typedef struct {
        logic [W-1:0] res;
        int           pulses;
        int           lat;
        logic         e;
    } exp_t;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    exp_t sb_q[$];
    op_t  op_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: counts pulses/latency of the accepted run and checks on done rise.
    initial begin : monitor
        int   mon_pulses;
        int   mon_lat;
        bit   mon_run;
        logic done_prev;
        exp_t ex;
        op_t  op;
        mon_pulses = 0; mon_lat = 0; mon_run = 0; done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mon_run   = 0;
                done_prev = 1'b0;
            end else begin
                if (mon_run) mon_lat++;
                if (mm_start) begin
                    mon_pulses++;
                    chk("mm_m", mm_m, W'(M));
                    if (op_q.size() > 0) begin
                        op = op_q.pop_front();
                        chk("op_a", mm_a, op.a);
                        chk("op_b", mm_b, op.b);
                    end
                end
                if (done && !done_prev) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", W'(1), W'(0));
                    end else begin
                        ex = sb_q.pop_front();
                        chk("result", result, ex.res);
                        chk("mm_start_pulses", W'(mon_pulses), W'(ex.pulses));
                        chk("done_latency", W'(mon_lat), W'(ex.lat));
                        chk("err_at_done", W'(err), W'(ex.e));
                    end
                    mon_run = 0;
                end
                if (start && !busy) begin
                    mon_run    = 1;
                    mon_pulses = 0;
                    mon_lat    = 0;
                end
                done_prev = done;
            end
        end
    end

    longint R, R2;

    task automatic launch(input int x, input int e, input int elen, input int res,
                          input int pulses, input int lat, input bit e_err, input bit push);
        in_x     = W'(x);
        in_e     = W'(e);
        in_e_len = EW'(elen);
        in_m     = W'(M);
        in_r     = W'(R);
        in_r2    = W'(R2);
        start    = 1'b1;
        if (push) sb_q.push_back('{res: W'(res), pulses: pulses, lat: lat, e: e_err});
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("done_low_after_start", W'(done), W'(0));
        chk("busy_after_start", W'(busy), W'(1));
        chk("err_clear_on_start", W'(err), W'(0));
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk({name, "_timeout"}, W'(0), W'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ops(input int base, input int k);
        bit seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (mk_ops - base >= k) seen = 1;
        end
        if (!seen) chk("wait_ops_timeout", W'(0), W'(1));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int     base;
        longint xt;
        resetn = 1'b0; start = 1'b0;
        in_x = '0; in_e = '0; in_e_len = '0; in_m = '0; in_r = '0; in_r2 = '0;
        R  = r_mod(M);
        R2 = (R * R) % M;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", W'(done), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_err", W'(err), W'(0));
        chk("rst_mm_start", W'(mm_start), W'(0));
        chk("rst_result", result, W'(0));
        chk("rst_mm_a", mm_a, W'(0));
        chk("rst_mm_b", mm_b, W'(0));
        chk("rst_mm_m", mm_m, W'(0));
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;

        // 4^13 mod 497
        launch(4, 13, 4, 445, 9, 41, 1'b0, 1'b1);
        wait_done("run_4_13");

        // e_len = 0 gives 1
        launch(200, 13, 0, 1, 2, 9, 1'b0, 1'b1);
        wait_done("run_elen0");

        // e = 1, with full operand sequence
        xt = mont(123, R2, M);
        op_q.push_back('{a: W'(123), b: W'(R2)});
        op_q.push_back('{a: W'(R),   b: W'(R)});
        op_q.push_back('{a: W'(R),   b: W'(xt)});
        op_q.push_back('{a: W'(xt),  b: W'(1)});
        launch(123, 1, 1, 123, 4, 18, 1'b0, 1'b1);
        wait_done("run_e1");

        // start during W_SQ with different inputs is ignored
        base = mk_ops;
        launch(4, 13, 4, 445, 9, 41, 1'b0, 1'b1);
        wait_ops(base, 2);
        @(posedge clk);
        #1 start = 1'b1; in_x = W'(9); in_e = W'(7); in_e_len = EW'(3);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("run_ignored_start");

        // reset while in W_MUL aborts the run
        base = mk_ops;
        launch(4, 13, 4, 0, 0, 0, 1'b0, 1'b0);
        wait_ops(base, 3);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("wmul_rst_busy", W'(busy), W'(0));
        chk("wmul_rst_done", W'(done), W'(0));
        chk("wmul_rst_mm_start", W'(mm_start), W'(0));
        chk("wmul_rst_mm_a", mm_a, W'(0));
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        launch(5, 3, 2, 125, 6, 27, 1'b0, 1'b1);
        wait_done("run_after_reset");

        // overflow bit on the first square sets sticky err
        inj_at = mk_ops + 1;
        launch(4, 13, 4, 445, 9, 41, 1'b1, 1'b1);
        wait_done("run_ovf");
        inj_at = -1;

        // err clears on the next accepted start
        launch(7, 2, 2, 49, 5, 23, 1'b0, 1'b1);
        wait_done("run_after_ovf");

        repeat (3) @(posedge clk);
        chk("sb_empty", W'(sb_q.size()), W'(0));
        chk("op_q_empty", W'(op_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
